// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH    = 64;
  localparam int unsigned REGFILE_DEPTH    = 32;
  localparam int unsigned REGFILE_ZERO_REG = 31;

  function automatic logic regfile_is_zero(input int unsigned addr,
                                           input int unsigned zero_reg = REGFILE_ZERO_REG);
    return addr == zero_reg;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: WIDTH-bit enabled data register plus a pending (busy) flop.
module regfile_cell #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_set,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  logic [WIDTH-1:0] r_data;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_we) r_data <= i_wdata;
      // A newly issued producer outranks the writeback of the previous one.
      if (i_set)      r_busy <= 1'b1;
      else if (i_clr) r_busy <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file with pending scoreboard, two combinational read ports and XZR.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = REGFILE_WIDTH,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned ZERO_REG = REGFILE_ZERO_REG,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             busy_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr
);

  logic [WIDTH-1:0] w_cell_data [DEPTH];
  logic [DEPTH-1:0] w_cell_busy;
  logic [AW-1:0]    w_raddr [2];
  logic [WIDTH-1:0] w_rdata [2];
  logic [1:0]       w_rbusy;
  logic             w_wr_ok;
  logic             w_set_ok;

  // Out-of-range and XZR targets are dropped before reaching any cell.
  assign w_wr_ok  = wr_en && !regfile_is_zero(32'(wr_addr), ZERO_REG) && (32'(wr_addr) < DEPTH);
  assign w_set_ok = busy_set && !regfile_is_zero(32'(busy_addr), ZERO_REG) && (32'(busy_addr) < DEPTH);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic w_hit_wr;
    logic w_hit_set;
    assign w_hit_wr  = w_wr_ok && (32'(wr_addr) == 32'(g));
    assign w_hit_set = w_set_ok && (32'(busy_addr) == 32'(g));

    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_hit_wr),
      .i_wdata (wr_data),
      .i_set   (w_hit_set),
      .i_clr   (w_hit_wr),
      .o_data  (w_cell_data[g]),
      .o_busy  (w_cell_busy[g])
    );
  end

  assign w_raddr[0] = rd_addr_a;
  assign w_raddr[1] = rd_addr_b;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      w_rbusy[p] = 1'b0;
      if (!regfile_is_zero(32'(w_raddr[p]), ZERO_REG) && (32'(w_raddr[p]) < DEPTH)) begin
        w_rdata[p] = w_cell_data[w_raddr[p]];
        w_rbusy[p] = w_cell_busy[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (wr_addr == w_raddr[p])) begin
          w_rdata[p] = wr_data;
          w_rbusy[p] = w_set_ok && (busy_addr == w_raddr[p]);
        end
`endif
      end
    end
  end

  assign rd_data_a = w_rdata[0];
  assign busy_a    = w_rbusy[0];
  assign rd_data_b = w_rdata[1];
  assign busy_b    = w_rbusy[1];

endmodule
